// File: rtl/madgwick_wb_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | madgwick_wb_sequencer: Wishbone master that runs one madgwick_top filter    |
// | step per IMU sample and returns the quaternion. Option macro: IRQ_WAIT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module madgwick_wb_sequencer #(
  parameter int ACC_W        = 16,
  parameter int GYRO_W       = 14,
  parameter int Q_W          = 32,
  parameter int DONE_TIMEOUT = 4096,
  parameter int POLL_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ACC_W-1:0]  s_a_x,
  input  logic [ACC_W-1:0]  s_a_y,
  input  logic [ACC_W-1:0]  s_a_z,
  input  logic [GYRO_W-1:0] s_w_x,
  input  logic [GYRO_W-1:0] s_w_y,
  input  logic [GYRO_W-1:0] s_w_z,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [Q_W-1:0]    q_w,
  output logic [Q_W-1:0]    q_x,
  output logic [Q_W-1:0]    q_y,
  output logic [Q_W-1:0]    q_z,
  output logic              busy,
  output logic              err_timeout,
  output logic [5:0]        adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  output logic              we_o,
  output logic              stb_o,
  output logic              cyc_o,
  input  logic              ack_i,
  input  logic              inta_i
);

`ifdef IRQ_WAIT_EN
  localparam logic [31:0] C_CTRL_BASE = 32'h0000_0009;
`else
  localparam logic [31:0] C_CTRL_BASE = 32'h0000_0001;
`endif
  localparam logic [31:0]       C_CTRL_START = 32'h0000_0002;
  localparam int                C_TMO_W      = $clog2(DONE_TIMEOUT + 1);
  localparam int                C_GAP_W      = $clog2(POLL_GAP + 1);
  localparam logic [C_TMO_W-1:0] C_TMO_MAX   = C_TMO_W'(DONE_TIMEOUT);
  localparam logic [C_GAP_W-1:0] C_GAP_RELOAD = C_GAP_W'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_INIT, S_WAIT_SAMPLE, S_WR_AX, S_WR_AY, S_WR_AZ, S_WR_WX, S_WR_WY, S_WR_WZ,
    S_WR_START, S_WAIT_DONE, S_CLR_START, S_RD_QW, S_RD_QX, S_RD_QY, S_RD_QZ, S_OUT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_cyc, r_we, r_err, r_busy;
  logic [5:0]          r_adr;
  logic [31:0]         r_dat;
  logic [C_GAP_W-1:0]  r_gap;
  logic [C_TMO_W-1:0]  r_tmo;
  logic [ACC_W-1:0]    r_ax, r_ay, r_az;
  logic [GYRO_W-1:0]   r_wx, r_wy, r_wz;
  logic [Q_W-1:0]      r_qw, r_qx, r_qy, r_qz;

  logic                w_cyc_nxt, w_we_nxt, w_err_nxt, w_tmo_clr;
  logic [5:0]          w_adr_nxt;
  logic [31:0]         w_dat_nxt;
  logic [C_GAP_W-1:0]  w_gap_nxt;
  logic                w_req, w_req_we, w_poll_go;
  logic [5:0]          w_req_adr;
  logic [31:0]         w_req_dat;
  logic                w_ack, w_expired, w_accept;

  assign w_ack     = r_cyc & ack_i;
  assign w_expired = (r_tmo == C_TMO_MAX);
  assign w_accept  = (r_state == S_WAIT_SAMPLE) & s_valid;

`ifdef IRQ_WAIT_EN
  assign w_poll_go = inta_i;
`else
  logic w_unused_inta;
  assign w_unused_inta = inta_i;
  assign w_poll_go     = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_gap_nxt   = r_gap;
    w_tmo_clr   = 1'b0;
    w_req       = 1'b0;
    w_req_we    = 1'b0;
    w_req_adr   = 6'h00;
    w_req_dat   = r_dat;
    case (r_state)
      S_INIT: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = C_CTRL_BASE;
        if (w_ack) w_state_nxt = S_WAIT_SAMPLE;
      end
      S_WAIT_SAMPLE: if (s_valid) begin
        w_state_nxt = S_WR_AX;
        w_err_nxt   = 1'b0;
      end
      S_WR_AX: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h04;
        w_req_dat = {{(32-ACC_W){r_ax[ACC_W-1]}}, r_ax};
        if (w_ack) w_state_nxt = S_WR_AY;
      end
      S_WR_AY: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h08;
        w_req_dat = {{(32-ACC_W){r_ay[ACC_W-1]}}, r_ay};
        if (w_ack) w_state_nxt = S_WR_AZ;
      end
      S_WR_AZ: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h0C;
        w_req_dat = {{(32-ACC_W){r_az[ACC_W-1]}}, r_az};
        if (w_ack) w_state_nxt = S_WR_WX;
      end
      S_WR_WX: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h10;
        w_req_dat = {{(32-GYRO_W){r_wx[GYRO_W-1]}}, r_wx};
        if (w_ack) w_state_nxt = S_WR_WY;
      end
      S_WR_WY: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h14;
        w_req_dat = {{(32-GYRO_W){r_wy[GYRO_W-1]}}, r_wy};
        if (w_ack) w_state_nxt = S_WR_WZ;
      end
      S_WR_WZ: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = 6'h18;
        w_req_dat = {{(32-GYRO_W){r_wz[GYRO_W-1]}}, r_wz};
        if (w_ack) w_state_nxt = S_WR_START;
      end
      S_WR_START: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = C_CTRL_BASE | C_CTRL_START;
        if (w_ack) begin
          w_state_nxt = S_WAIT_DONE;
          w_tmo_clr   = 1'b1;
          w_gap_nxt   = '0;
        end
      end
      // Done seen on the expiry cycle wins; an in-flight poll always completes.
      S_WAIT_DONE: begin
        if (w_ack) begin
          if (dat_i[2]) begin
            w_state_nxt = S_CLR_START;
          end else if (w_expired) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_CLR_START;
          end else begin
            w_gap_nxt = C_GAP_RELOAD;
          end
        end else if (!r_cyc) begin
          if (w_expired) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_CLR_START;
          end else if (r_gap != '0) begin
            w_gap_nxt = r_gap - C_GAP_W'(1);
          end else begin
            w_req = w_poll_go;
          end
        end
      end
      S_CLR_START: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = C_CTRL_BASE;
        if (w_ack) w_state_nxt = r_err ? S_WAIT_SAMPLE : S_RD_QW;
      end
      S_RD_QW: begin w_req = 1'b1; w_req_adr = 6'h1C; if (w_ack) w_state_nxt = S_RD_QX; end
      S_RD_QX: begin w_req = 1'b1; w_req_adr = 6'h20; if (w_ack) w_state_nxt = S_RD_QY; end
      S_RD_QY: begin w_req = 1'b1; w_req_adr = 6'h24; if (w_ack) w_state_nxt = S_RD_QZ; end
      S_RD_QZ: begin w_req = 1'b1; w_req_adr = 6'h28; if (w_ack) w_state_nxt = S_OUT;   end
      S_OUT:   if (q_ready) w_state_nxt = S_WAIT_SAMPLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // A new access can only start from an idle bus, which guarantees the gap cycle.
  always_comb begin
    w_cyc_nxt = r_cyc;
    w_we_nxt  = r_we;
    w_adr_nxt = r_adr;
    w_dat_nxt = r_dat;
    if (w_ack) begin
      w_cyc_nxt = 1'b0;
      w_we_nxt  = 1'b0;
    end else if (!r_cyc && w_req) begin
      w_cyc_nxt = 1'b1;
      w_we_nxt  = w_req_we;
      w_adr_nxt = w_req_adr;
      w_dat_nxt = w_req_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cyc   <= 1'b0;  r_we  <= 1'b0;  r_err <= 1'b0;  r_busy <= 1'b0;
      r_adr   <= '0;    r_dat <= '0;    r_gap <= '0;    r_tmo  <= '0;
      r_ax    <= '0;    r_ay  <= '0;    r_az  <= '0;
      r_wx    <= '0;    r_wy  <= '0;    r_wz  <= '0;
      r_qw    <= '0;    r_qx  <= '0;    r_qy  <= '0;    r_qz   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
      r_err   <= w_err_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= (w_state_nxt != S_WAIT_SAMPLE);
      if (w_accept) begin
        r_ax <= s_a_x;  r_ay <= s_a_y;  r_az <= s_a_z;
        r_wx <= s_w_x;  r_wy <= s_w_y;  r_wz <= s_w_z;
      end
      if (w_tmo_clr) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT_DONE && !w_expired) begin
        r_tmo <= r_tmo + C_TMO_W'(1);
      end
      if (w_ack) begin
        case (r_state)
          S_RD_QW: r_qw <= dat_i[Q_W-1:0];
          S_RD_QX: r_qx <= dat_i[Q_W-1:0];
          S_RD_QY: r_qy <= dat_i[Q_W-1:0];
          S_RD_QZ: r_qz <= dat_i[Q_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign s_ready     = (r_state == S_WAIT_SAMPLE);
  assign q_valid     = (r_state == S_OUT);
  assign q_w         = r_qw;
  assign q_x         = r_qx;
  assign q_y         = r_qy;
  assign q_z         = r_qz;
  assign busy        = r_busy;
  assign err_timeout = r_err;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign we_o        = r_we;
  assign stb_o       = r_cyc;
  assign cyc_o       = r_cyc;

endmodule
`default_nettype wire

// File: doc/madgwick_wb_sequencer.md
Name: madgwick_wb_sequencer

Overview:
Wishbone master that drives the madgwick_top register slave autonomously, so no CPU is needed in the loop. It accepts one IMU sample per handshake, writes the six sensor registers, pulses the filter through the control-register start/done protocol, reads back the four quaternion words and presents them on a valid/ready output. It sits between the sensor front-end and madgwick_top.

Parameters:
ACC_W, 16, accelerometer sample width (signed, two's complement)
GYRO_W, 14, gyroscope sample width (signed)
Q_W, 32, quaternion word width returned on the bus
DONE_TIMEOUT, 4096, cycles allowed from start write to done observed
POLL_GAP, 2, idle cycles between consecutive control-register polls (minimum 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid&&s_ready
s_a_x, s_a_y, s_a_z  in  ACC_W  accelerometer sample
s_w_x, s_w_y, s_w_z  in  GYRO_W  gyroscope sample
q_valid  out  1  quaternion result valid
q_ready  in  1  downstream accepts result
q_w, q_x, q_y, q_z  out  Q_W  quaternion result
busy  out  1  high whenever state != IDLE/WAIT_SAMPLE
err_timeout  out  1  sticky; set on done timeout, cleared by reset or by next accepted sample
adr_o  out  6  Wishbone address
dat_o  out  32  Wishbone write data
dat_i  in  32  Wishbone read data
we_o  out  1  write enable
stb_o, cyc_o  out  1  strobe / cycle (always driven equal)
ack_i  in  1  slave acknowledge
inta_i  in  1  slave interrupt (used only with IRQ_WAIT_EN)

Behaviour:
- Clock is clk; reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Register map: 0x00 CTRL (bit0 enable, bit1 start, bit2 done, bit3 int_en), 0x04/08/0C a_x/a_y/a_z, 0x10/14/18 w_x/w_y/w_z, 0x1C/20/24/28 q_w/q_x/q_y/q_z.
- Reset: cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, s_ready=0, q_valid=0, q outputs=0, busy=0, err_timeout=0; FSM -> INIT. A reset mid-transaction drops cyc_o/stb_o in the same edge. The transaction is not completed.
- Bus cycle: adr_o/dat_o/we_o are set and cyc_o=stb_o=1 on the same edge. They are held stable until ack_i is sampled high. On that edge cyc_o/stb_o/we_o drop and read data is captured from dat_i. There is at least one idle cycle before the next cycle. With zero-wait ack, each access takes 3 cycles.
- FSM states:
  - INIT: write CTRL=0x01 (0x09 with IRQ_WAIT_EN).
  - WAIT_SAMPLE: s_ready=1; on handshake, latch all six inputs and clear err_timeout.
  - WR_AX..WR_WZ: six writes in address order. Data is sign-extended to 32 bits.
  - WR_START: write CTRL with bit1 set; the done-timeout counter starts.
  - POLL: read CTRL; if bit2=1 go to CLR_START, else spend POLL_GAP idle cycles and read again.
  - CLR_START: write CTRL with bit1 cleared.
  - RD_QW..RD_QZ: four reads into the q registers.
  - OUT: q_valid=1, held with data stable until q_ready; then return to WAIT_SAMPLE.
- s_ready is 1 only in WAIT_SAMPLE. No new sample is accepted while a result is pending, so there is no buffering.
- Timeout: if done has not been seen DONE_TIMEOUT cycles after the WR_START ack, set err_timeout and let any in-flight access finish. Then go to CLR_START, skip the reads, and return to WAIT_SAMPLE without asserting q_valid.
- The counter saturates. Done observed on the same cycle as the timeout expiry counts as success.
- Write data for WR_AX: {{(32-ACC_W){s_a_x[ACC_W-1]}}, s_a_x}; the gyro fields follow the same rule.

Optional Feature:
IRQ_WAIT_EN:
- Defined:
  - INIT and all CTRL writes also set int_en (bit3).
  - POLL is replaced by WAIT_IRQ, which issues no bus cycles until inta_i=1, then performs one CTRL read.
  - If that read shows bit2=0, the block returns to WAIT_IRQ.
  - The timeout still applies.
- Undefined: inta_i is ignored, bit3 is always 0, and polling is used.

Test Plan:
- Reset then release, zero-wait slave -> first cycle is a write to adr 0x00 with data 0x01, which completes in 3 cycles; s_ready rises after that.
- Sample a_x=0x1838, a_y=0x014A, a_z=0x00C4, w_x=0x3F1F, w_y=0x005C, w_z=0x3F54 -> writes 0x00001838, 0x0000014A, 0x000000C4, 0xFFFFFF1F, 0x0000005C, 0xFFFFFF54 to 0x04..0x18 in order, then CTRL=0x03.
- Slave raises done after 100 cycles, returns q=0x11111111/22222222/33333333/44444444 -> CTRL=0x01 written, four reads to 0x1C..0x28, and q_valid shows those values. Hold q_ready=0 for 10 cycles: outputs are stable and s_ready=0.
- Slave inserts 3 wait states on every ack -> stb/adr/dat are held, no duplicate accesses, results are identical.
- Done never set -> err_timeout=1 about 4096 cycles after the start ack, CTRL=0x01 written, no q_valid, s_ready=1; the next sample clears err_timeout.
- rst_n=0 while stb_o=1 during WR_AY -> next edge cyc_o=stb_o=0, and after release the sequence restarts from INIT.
